md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 91 +++++++++
 tb/tb_md_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// Signed operations run on magnitudes; signs and divide-by-zero results are applied in FINISH.
module md_unit #(
  parameter logic [31:0] DBZ_QUOT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic [63:0] r_acc;
  logic        w_neg_a, w_neg_b, w_dbz;
  logic [31:0] w_mag_a, w_mag_b, w_quot, w_rem, w_res_hi, w_res_lo;
  logic [63:0] w_acc, w_mul_step, w_div_step, w_step, w_prod;
  logic [32:0] w_sum, w_trial;
  always_comb begin
    w_neg_a  = ~r_op[0] & r_a[31];
    w_neg_b  = ~r_op[0] & r_b[31];
    w_mag_a  = w_neg_a ? -r_a : r_a;
    w_mag_b  = w_neg_b ? -r_b : r_b;
    // first step seeds the accumulator with the multiplier (mul) or dividend (div)
    w_acc    = (r_cnt == 6'd0) ? {32'd0, r_op[1] ? w_mag_a : w_mag_b} : r_acc;
    w_sum    = {1'b0, w_acc[63:32]} + (w_acc[0] ? {1'b0, w_mag_a} : 33'd0);
    w_mul_step = {w_sum, w_acc[31:1]};
    w_trial  = w_acc[63:31] - {1'b0, w_mag_b};
    w_div_step = w_trial[32] ? {w_acc[62:0], 1'b0} : {w_trial[31:0], w_acc[30:0], 1'b1};
    w_step   = r_op[1] ? w_div_step : w_mul_step;
    w_prod   = (w_neg_a ^ w_neg_b) ? -r_acc : r_acc;
    w_quot   = (w_neg_a ^ w_neg_b) ? -r_acc[31:0] : r_acc[31:0];
    w_rem    = w_neg_a ? -r_acc[63:32] : r_acc[63:32];
    w_dbz    = (r_b == 32'd0);
    w_res_hi = !r_op[1] ? w_prod[63:32] : w_dbz ? r_a : w_rem;
    w_res_lo = !r_op[1] ? w_prod[31:0] : w_dbz ? DBZ_QUOT : w_quot;
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && start) w_next = RUN;
    else if (r_state == RUN && r_cnt == 6'd31) w_next = FINISH;
    else if (r_state == FINISH) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_op  <= op;
        r_a   <= a;
        r_b   <= b;
        r_cnt <= '0;
        r_acc <= '0;
      end else if (r_state == IDLE) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
      if (r_state == RUN) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + 6'd1;
      end
      if (r_state == FINISH) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end
  assign busy = (r_state != IDLE);
  assign done = (r_state == FINISH);
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and random checks of md_unit against an arithmetic reference model.
module tb_md_unit;
  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  md_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx = longint'($signed(x));
    longint      sy = longint'($signed(y));
    logic [63:0] ux = {32'd0, x};
    logic [63:0] uy = {32'd0, y};
    longint      q, r;
    logic [63:0] uq, ur;
    if (o == 2'd0) return sx * sy;
    if (o == 2'd1) return ux * uy;
    if (y == 32'd0) return {x, 32'hFFFFFFFF};
    if (o == 2'd2) begin
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
    end
    uq = ux / uy;
    ur = ux % uy;
    return {ur[31:0], uq[31:0]};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit wr, input bit ifr);
    logic [63:0] e;
    bit early;
    e = model(o, x, y);
    early = 0;
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    hi_we = wr; lo_we = wr; wdata = $urandom;
    tick();
    start = 0; hi_we = 0; lo_we = 0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    chk("busy_rise", {63'd0, busy}, 64'd1);
    for (int k = 1; k <= 32; k++) begin
      if (ifr && k == 5) begin start = 1; a = $urandom; b = $urandom; op = 2'($urandom); end
      if (ifr && k == 10) begin hi_we = 1; lo_we = 1; wdata = 32'hDEAD; end
      tick();
      start = 0; hi_we = 0; lo_we = 0;
      if (k < 32) early = early | done;
    end
    chk("early_done", {63'd0, early}, 64'd0);
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("hold_hilo", {hi, lo}, {m_hi, m_lo});
    tick();
    chk("done_drop", {62'd0, done, busy}, 64'd0);
    chk($sformatf("result op%0d a=%h b=%h", o, x, y), {hi, lo}, e);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask
  initial begin
    bit seen;
    logic [31:0] v;
    rst = 1; start = 0; hi_we = 0; lo_we = 0; op = '0; a = '0; b = '0; wdata = '0;
    tick();
    start = 1; hi_we = 1; lo_we = 1; wdata = 32'h1111_2222;
    tick();
    chk("rst_state", {30'd0, busy, done, hi, lo}, 64'd0);
    rst = 0; start = 0; hi_we = 0; lo_we = 0;
    tick();
    chk("rst_prio_busy", {63'd0, busy}, 64'd0);
    v = $urandom;
    @(negedge clk); hi_we = 1; wdata = v;
    tick(); hi_we = 0;
    chk("mthi", {hi, lo}, {v, 32'd0});
    @(negedge clk); lo_we = 1; wdata = ~v;
    tick(); lo_we = 0;
    chk("mtlo", {hi, lo}, {v, ~v});
    @(negedge clk); hi_we = 1; lo_we = 1; wdata = 32'hA5A5_0F0F;
    tick(); hi_we = 0; lo_we = 0;
    chk("mthilo", {hi, lo}, {32'hA5A5_0F0F, 32'hA5A5_0F0F});
    m_hi = hi; m_lo = lo;
    chk("mult_neg2x7", model(2'd0, 32'hFFFFFFFE, 32'd7), 64'hFFFFFFFF_FFFFFFF2);
    do_op(2'd0, 32'hFFFFFFFE, 32'd7, 0, 0);
    do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
    chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    do_op(2'd2, 32'hFFFFFFF9, 32'd2, 0, 0);
    chk("div_m7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(2'd3, 32'd7, 32'd2, 0, 0);
    chk("divu_7_2", {hi, lo}, 64'h00000001_00000003);
    do_op(2'd3, 32'h1234, 32'd0, 0, 0);
    chk("divu_dbz", {hi, lo}, 64'h00001234_FFFFFFFF);
    do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    chk("div_ovf", {hi, lo}, 64'h00000000_80000000);
    do_op(2'd2, 32'h00000007, 32'hFFFFFFFE, 0, 0);
    do_op(2'd2, 32'h80000000, 32'd0, 0, 0);
    do_op(2'd0, 32'h12345678, 32'h9ABCDEF0, 0, 1);
    for (int i = 0; i < 24; i++) begin
      v = (i % 6 == 5) ? 32'd0 : $urandom;
      do_op(2'($urandom), $urandom, v, 1'($urandom), 0);
    end
    @(negedge clk); start = 1; op = 2'd2; a = $urandom; b = $urandom;
    tick(); start = 0;
    for (int k = 1; k < 16; k++) tick();
    @(negedge clk); rst = 1;
    @(posedge clk); #1; rst = 0;
    chk("mid_rst", {30'd0, busy, done, hi, lo}, 64'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      seen = seen | done | busy;
    end
    chk("no_done_after_rst", {63'd0, seen}, 64'd0);
    @(negedge clk); lo_we = 1; wdata = 32'd5;
    tick(); lo_we = 0;
    chk("mtlo_after_rst", {hi, lo}, 64'd5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
